// File: rtl/dco_sar_cal_ctrl.sv
// SAR calibration sequencer for the ADPLL DCO coarse code, run on the reference clock.
// Define CAL_TOL_EN to finish early once a measurement lands within TOL counts of target.
module dco_sar_cal_ctrl #(
   parameter int CODE_W     = 6,
   parameter int SETTLE_CYC = 8,
   parameter int SYNC_CYC   = 4,
   parameter int TOL        = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cal_start,
   input  logic              cal_abort,
   input  logic [14:0]       count_window,
   input  logic [14:0]       target_count,
   input  logic [14:0]       compared_count,
   output logic              calibration_mode,
   output logic              clk_count_start,
   output logic [14:0]       count_untill,
   output logic [CODE_W-1:0] dco_code,
   output logic              cal_busy,
   output logic              cal_done,
   output logic              cal_err
);
   // state  | meaning
   // IDLE   | waiting for cal_start
   // SETTLE | trial code applied, comparator counters held clear
   // COUNT  | count window plus sync margin running
   // SAMPLE | capture compared_count
   // DECIDE | resolve current bit, pick next trial
   // DONE   | final code held, leaving calibration mode
   typedef enum logic [2:0] {
      S_IDLE, S_SETTLE, S_COUNT, S_SAMPLE, S_DECIDE, S_DONE
   } state_t;

   localparam int IDX_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;
   localparam logic [IDX_W-1:0] IDX_MSB   = IDX_W'(CODE_W - 1);
   localparam logic [15:0]      SETTLE_LD = 16'(SETTLE_CYC - 1);
`ifdef CAL_TOL_EN
   localparam logic TOL_ON = 1'b1;
`else
   localparam logic TOL_ON = 1'b0;
`endif

   state_t              state, state_n;
   logic [15:0]         timer, timer_n;
   logic [IDX_W-1:0]    bit_idx, idx_n;
   logic [CODE_W-1:0]   code_prev, prev_n, code_n;
   logic [14:0]         meas_q, meas_n, target_q, tgt_n, win_n;
   logic                mode_n, busy_n, done_n, err_n, ccs_n;
   logic signed [16:0]  diff, diff_abs;
   logic                tol_hit;
   logic [15:0]         count_ld;

   assign count_ld = {1'b0, count_untill} + 16'(SYNC_CYC) - 16'd1;
   assign diff     = $signed({2'b00, meas_q}) - $signed({2'b00, target_q});
   assign diff_abs = diff[16] ? -diff : diff;
   assign tol_hit  = TOL_ON && (diff_abs <= $signed(17'(TOL)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= S_IDLE;
         timer            <= '0;
         bit_idx          <= '0;
         code_prev        <= '0;
         meas_q           <= '0;
         target_q         <= '0;
         count_untill     <= '0;
         dco_code         <= '0;
         calibration_mode <= 1'b0;
         clk_count_start  <= 1'b0;
         cal_busy         <= 1'b0;
         cal_done         <= 1'b0;
         cal_err          <= 1'b0;
      end else begin
         state            <= state_n;
         timer            <= timer_n;
         bit_idx          <= idx_n;
         code_prev        <= prev_n;
         meas_q           <= meas_n;
         target_q         <= tgt_n;
         count_untill     <= win_n;
         dco_code         <= code_n;
         calibration_mode <= mode_n;
         clk_count_start  <= ccs_n;
         cal_busy         <= busy_n;
         cal_done         <= done_n;
         cal_err          <= err_n;
      end
   end

   always_comb begin
      state_n = state;
      timer_n = timer;
      idx_n   = bit_idx;
      prev_n  = code_prev;
      code_n  = dco_code;
      meas_n  = meas_q;
      tgt_n   = target_q;
      win_n   = count_untill;
      mode_n  = calibration_mode;
      busy_n  = cal_busy;
      done_n  = cal_done;
      err_n   = cal_err;

      case (state)
         S_IDLE: begin
            if (cal_start) begin
               if (count_window != 15'd0) begin
                  win_n   = count_window;
                  tgt_n   = target_count;
                  prev_n  = dco_code;
                  idx_n   = IDX_MSB;
                  code_n  = '0;
                  code_n[CODE_W-1] = 1'b1;
                  mode_n  = 1'b1;
                  busy_n  = 1'b1;
                  done_n  = 1'b0;
                  err_n   = 1'b0;
                  timer_n = SETTLE_LD;
                  state_n = S_SETTLE;
               end else begin
                  err_n  = 1'b1;
                  done_n = 1'b1;
               end
            end
         end
         S_SETTLE: begin
            if (timer == 16'd0) begin
               timer_n = count_ld;
               state_n = S_COUNT;
            end else begin
               timer_n = timer - 16'd1;
            end
         end
         S_COUNT: begin
            if (timer == 16'd0) state_n = S_SAMPLE;
            else                timer_n = timer - 16'd1;
         end
         S_SAMPLE: begin
            meas_n  = compared_count;
            state_n = S_DECIDE;
         end
         S_DECIDE: begin
            // Within tolerance the trial code is final as-is, bit untouched.
            if (tol_hit) begin
               state_n = S_DONE;
            end else begin
               if (meas_q > target_q) code_n[bit_idx] = 1'b0;
               if (bit_idx == '0) begin
                  state_n = S_DONE;
               end else begin
                  idx_n         = bit_idx - 1'b1;
                  code_n[idx_n] = 1'b1;
                  timer_n       = SETTLE_LD;
                  state_n       = S_SETTLE;
               end
            end
         end
         S_DONE: begin
            mode_n  = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase

      if (cal_abort && state != S_IDLE) begin
         state_n = S_IDLE;
         code_n  = code_prev;
         mode_n  = 1'b0;
         busy_n  = 1'b0;
         done_n  = 1'b0;
      end

      ccs_n = (state_n == S_COUNT) || (state_n == S_SAMPLE);
   end
endmodule

// File: tb/tb_dco_sar_cal_ctrl.sv
// Bench for dco_sar_cal_ctrl: comparator modelled as compared_count = 2*dco_code.
// Expected results follow CAL_TOL_EN when it is defined for the build.
module tb_dco_sar_cal_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cal_start = 1'b0;
   logic        cal_abort = 1'b0;
   logic [14:0] count_window = '0;
   logic [14:0] target_count = '0;
   logic [14:0] compared_count;
   logic        calibration_mode, clk_count_start, cal_busy, cal_done, cal_err;
   logic [14:0] count_untill;
   logic [5:0]  dco_code;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   assign compared_count = {8'd0, dco_code, 1'b0};

   dco_sar_cal_ctrl #(.CODE_W(6), .SETTLE_CYC(8), .SYNC_CYC(4), .TOL(2)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .cal_start        (cal_start),
      .cal_abort        (cal_abort),
      .count_window     (count_window),
      .target_count     (target_count),
      .compared_count   (compared_count),
      .calibration_mode (calibration_mode),
      .clk_count_start  (clk_count_start),
      .count_untill     (count_untill),
      .dco_code         (dco_code),
      .cal_busy         (cal_busy),
      .cal_done         (cal_done),
      .cal_err          (cal_err)
   );

   typedef struct {
      int win;
      int tgt;
      int code;
      int steps;
   } vec_t;

   vec_t vecs[6];
   int   trials[$];

   task automatic chk(input string name, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic start_cal(input int win, input int tgt);
      @(negedge clk);
      count_window = 15'(win);
      target_count = 15'(tgt);
      cal_start    = 1'b1;
      @(posedge clk);
      #1;
      cal_start = 1'b0;
   endtask

   task automatic run_vec(input int i);
      int n;
      logic prev_ccs;
      int exp_trials[6];
      exp_trials = '{32, 48, 40, 44, 42, 41};
      start_cal(vecs[i].win, vecs[i].tgt);
      chk($sformatf("v%0d busy_at_accept", i), int'(cal_busy), 1);
      chk($sformatf("v%0d mode_at_accept", i), int'(calibration_mode), 1);
      chk($sformatf("v%0d first_trial", i), int'(dco_code), 32);
      chk($sformatf("v%0d count_untill", i), int'(count_untill), vecs[i].win);
      chk($sformatf("v%0d done_cleared", i), int'(cal_done), 0);
      trials.delete();
      n = 0;
      prev_ccs = clk_count_start;
      while (n < 3000 && !cal_done) begin
         @(posedge clk);
         #1;
         n++;
         if (clk_count_start && !prev_ccs) trials.push_back(int'(dco_code));
         prev_ccs = clk_count_start;
      end
      chk($sformatf("v%0d latency", i), n, vecs[i].steps * (8 + vecs[i].win + 4 + 2) + 1);
      chk($sformatf("v%0d code", i), int'(dco_code), vecs[i].code);
      chk($sformatf("v%0d mode_off", i), int'(calibration_mode), 0);
      chk($sformatf("v%0d busy_off", i), int'(cal_busy), 0);
      chk($sformatf("v%0d steps", i), trials.size(), vecs[i].steps);
      if (i == 0) begin
         for (int k = 0; k < trials.size() && k < 6; k++)
            chk($sformatf("v0 trial%0d", k), trials[k], exp_trials[k]);
      end
      @(posedge clk);
      #1;
      chk($sformatf("v%0d done_sticky", i), int'(cal_done), 1);
   endtask

   initial begin
      int rises;
      int n;
      int exp_prev;
      logic prev_ccs;
      logic mode_seen;

`ifdef CAL_TOL_EN
      vecs[0] = '{win: 100, tgt: 80,  code: 40, steps: 3};
      vecs[1] = '{win: 100, tgt: 0,   code: 1,  steps: 6};
      vecs[2] = '{win: 100, tgt: 200, code: 63, steps: 6};
      vecs[3] = '{win: 100, tgt: 64,  code: 32, steps: 1};
      vecs[4] = '{win: 1,   tgt: 50,  code: 24, steps: 3};
      vecs[5] = '{win: 10,  tgt: 34,  code: 16, steps: 2};
`else
      vecs[0] = '{win: 100, tgt: 80,  code: 40, steps: 6};
      vecs[1] = '{win: 100, tgt: 0,   code: 0,  steps: 6};
      vecs[2] = '{win: 100, tgt: 200, code: 63, steps: 6};
      vecs[3] = '{win: 100, tgt: 64,  code: 32, steps: 6};
      vecs[4] = '{win: 1,   tgt: 50,  code: 25, steps: 6};
      vecs[5] = '{win: 10,  tgt: 34,  code: 17, steps: 6};
`endif

      #1;
      chk("rst dco_code", int'(dco_code), 0);
      chk("rst mode", int'(calibration_mode), 0);
      chk("rst ccs", int'(clk_count_start), 0);
      chk("rst busy", int'(cal_busy), 0);
      chk("rst done", int'(cal_done), 0);
      chk("rst err", int'(cal_err), 0);
      chk("rst count_untill", int'(count_untill), 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) run_vec(i);
      exp_prev = vecs[5].code;

      // abort during the third COUNT restores the previous code
      start_cal(10, 100);
      rises = 0;
      n = 0;
      prev_ccs = clk_count_start;
      while (rises < 3 && n < 500) begin
         @(posedge clk);
         #1;
         n++;
         if (clk_count_start && !prev_ccs) rises++;
         prev_ccs = clk_count_start;
      end
      chk("abort reached_count3", rises, 3);
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("abort in_count", int'(clk_count_start), 1);
      cal_abort = 1'b1;
      @(posedge clk);
      #1;
      cal_abort = 1'b0;
      chk("abort code", int'(dco_code), exp_prev);
      chk("abort busy", int'(cal_busy), 0);
      chk("abort done", int'(cal_done), 0);
      chk("abort ccs", int'(clk_count_start), 0);
      chk("abort mode", int'(calibration_mode), 0);

      // zero window is rejected
      start_cal(0, 50);
      chk("zw err", int'(cal_err), 1);
      chk("zw done", int'(cal_done), 1);
      chk("zw code", int'(dco_code), exp_prev);
      chk("zw busy", int'(cal_busy), 0);
      mode_seen = calibration_mode;
      repeat (5) begin
         @(posedge clk);
         #1;
         mode_seen = mode_seen | calibration_mode;
      end
      chk("zw mode_never", int'(mode_seen), 0);

      // async reset in the middle of SETTLE
      start_cal(10, 34);
      chk("rs err_cleared", int'(cal_err), 0);
      repeat (3) @(posedge clk);
      #1;
      chk("rs in_settle_mode", int'(calibration_mode), 1);
      rst_n = 1'b0;
      #1;
      chk("rs dco_code", int'(dco_code), 0);
      chk("rs mode", int'(calibration_mode), 0);
      chk("rs busy", int'(cal_busy), 0);
      chk("rs ccs", int'(clk_count_start), 0);
      chk("rs count_untill", int'(count_untill), 0);
      chk("rs done", int'(cal_done), 0);
      chk("rs err", int'(cal_err), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
